seq_add64: RTL and testbench

//  Multi-cycle wide adder that wraps the 16-bit carry-lookahead adder: latches two

---
 rtl/seq_add64_pkg.sv | 13 +
 rtl/seq_add64_cla16.sv | 52 +++++
 rtl/seq_add64.sv | 132 +++++++++++++
 tb/tb_seq_add64.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_add64_pkg.sv
// Shared constants for the sliced wide adder: slice geometry and FSM state encoding.
package seq_add64_pkg;

  localparam int SLICE    = 16;
  localparam int SLICE_LG = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_add64_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a group-level lookahead.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        g,
  output logic        p
);

  logic [15:0] gi;
  logic [15:0] pi;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic        carry;

  assign gi = a & b;
  assign pi = a ^ b;

  always_comb begin
    gg    = '0;
    gp    = '0;
    gc    = '0;
    sum   = '0;
    carry = 1'b0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = gi[4*j+3]
            | (pi[4*j+3] & gi[4*j+2])
            | (pi[4*j+3] & pi[4*j+2] & gi[4*j+1])
            | (pi[4*j+3] & pi[4*j+2] & pi[4*j+1] & gi[4*j]);
      gp[j] = &pi[4*j +: 4];
    end
    gc[0] = cin;
    for (int j = 0; j < 4; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    // Within a group the carry restarts from the lookahead group carry-in.
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) carry = gc[i/4];
      sum[i] = pi[i] ^ carry;
      carry  = gi[i] | (pi[i] & carry);
    end
  end

  assign cout = gc[4];
  assign g    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);
  assign p    = &gp;

endmodule

// File: rtl/seq_add64.sv
// Multi-cycle wide adder: one CLA16 slice per cycle, LSB first, carry registered between slices.
//   state  | meaning
//   S_IDLE | waiting for start; result registers hold the last answer
//   S_RUN  | slice k going through the CLA16, busy=1
//   S_DONE | done pulse, result valid
module seq_add64
  import seq_add64_pkg::*;
#(
  parameter int NCHUNK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SLICE*NCHUNK-1:0] a,
  input  logic [SLICE*NCHUNK-1:0] b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [SLICE*NCHUNK-1:0] sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W  = SLICE * NCHUNK;
  localparam int CW = $clog2(NCHUNK);
  localparam logic [CW-1:0] K_LAST = CW'(NCHUNK - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [CW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [CW+SLICE_LG-1:0] base;
  logic [SLICE-1:0]       cla_a;
  logic [SLICE-1:0]       cla_b;
  logic [SLICE-1:0]       cla_sum;
  logic                   cla_cout;

  assign base  = {k_q, {SLICE_LG{1'b0}}};
  assign cla_a = a_q[base +: SLICE];
  assign cla_b = b_q[base +: SLICE];

  cla16 u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout),
    .g    (),
    .p    ()
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    k_d     = k_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[base +: SLICE] = cla_sum;
        carry_d              = cla_cout;
        if (k_q == K_LAST) begin
          cout_d  = cla_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_sum[SLICE-1] != a_q[W-1]);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d    = k_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_add64.sv
// Self-checking bench for seq_add64: directed vector table and corner sequences on NCHUNK=4,
// plus random adds on NCHUNK=2,4,8 against an arithmetic reference model.
module tb_seq_add64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start2 = 1'b0, start4 = 1'b0, start8 = 1'b0;
  logic [127:0] a_w = '0, b_w = '0;
  logic         cin = 1'b0;

  logic         busy2, done2, cout2, ovf2;
  logic         busy4, done4, cout4, ovf4;
  logic         busy8, done8, cout8, ovf8;
  logic [31:0]  sum2;
  logic [63:0]  sum4;
  logic [127:0] sum8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_add64 #(.NCHUNK(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a_w[31:0]), .b(b_w[31:0]), .cin(cin),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  seq_add64 #(.NCHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a_w[63:0]), .b(b_w[63:0]), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

  seq_add64 #(.NCHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a_w), .b(b_w), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Unsigned result is the low w bits of a+b+cin; signed overflow is the sign-extended
  // sum not fitting in w bits.
  function automatic void ref_add(input int w, input logic [127:0] a, input logic [127:0] b,
                                  input logic c, output logic [127:0] s,
                                  output logic co, output logic ov);
    logic [129:0] mask, am, bm, full, sa, sb, ssum;
    mask = (130'd1 << w) - 130'd1;
    am   = {2'b00, a} & mask;
    bm   = {2'b00, b} & mask;
    full = am + bm + {129'd0, c};
    s    = full[127:0] & mask[127:0];
    co   = full[w];
    sa   = am[w-1] ? (am | ~mask) : am;
    sb   = bm[w-1] ? (bm | ~mask) : bm;
    ssum = sa + sb + {129'd0, c};
    ov   = ssum[w] != ssum[w-1];
  endfunction

  // Starts one op on dut4 from IDLE; returns edges to done and cycles busy was seen high.
  task automatic op4(input logic [63:0] a, input logic [63:0] b, input logic c,
                     output int lat, output int busy_cnt);
    a_w    = {64'd0, a};
    b_w    = {64'd0, b};
    cin    = c;
    start4 = 1'b1;
    tick();
    start4   = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done4 && lat < 20) begin
      if (busy4) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, saw_done, cyc;
    logic got2, got4, got8;
    logic [127:0] ra, rb, es;
    logic rc, eco, eov;

    vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
                64'h2222_2222_2222_2212, 1'b0, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

    // Reset held with start asserted.
    rst    = 1'b1;
    start4 = 1'b1;
    a_w    = {64'd0, 64'hDEAD_BEEF_1234_5678};
    b_w    = {64'd0, 64'h1111_2222_3333_4444};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_busy", {127'd0, busy4}, 128'd0);
      check("rst_done", {127'd0, done4}, 128'd0);
      check("rst_sum", {64'd0, sum4}, 128'd0);
      check("rst_cout", {127'd0, cout4}, 128'd0);
      check("rst_ovf", {127'd0, ovf4}, 128'd0);
    end
    start4 = 1'b0;
    rst    = 1'b0;
    tick();

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
      check($sformatf("vec%0d_busy_cycles", i), 128'(bcnt), 128'd4);
      check($sformatf("vec%0d_busy_at_done", i), {127'd0, busy4}, 128'd0);
      check($sformatf("vec%0d_sum", i), {64'd0, sum4}, {64'd0, vecs[i].sum});
      check($sformatf("vec%0d_cout", i), {127'd0, cout4}, {127'd0, vecs[i].cout});
      check($sformatf("vec%0d_ovf", i), {127'd0, ovf4}, {127'd0, vecs[i].ovf});
      tick();
      check($sformatf("vec%0d_done_pulse", i), {127'd0, done4}, 128'd0);
    end

    // Start while busy is ignored; result held in IDLE; back-to-back start accepted.
    a_w = {64'd0, 64'd1}; b_w = {64'd0, 64'd2}; cin = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    a_w = {64'd0, 64'h0F0F_0000_0000_0000}; b_w = {64'd0, 64'h0101}; cin = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 2;
    while (!done4 && lat < 20) begin tick(); lat++; end
    check("busy_start_latency", 128'(lat), 128'd4);
    check("busy_start_sum", {64'd0, sum4}, 128'd3);
    tick();
    check("hold_sum_idle", {64'd0, sum4}, 128'd3);
    check("hold_idle_busy", {127'd0, busy4}, 128'd0);
    op4(64'h0000_0001_0000_FFFF, 64'h0000_0002_0000_0001, 1'b0, lat, bcnt);
    check("b2b_latency", 128'(lat), 128'd4);
    check("b2b_sum", {64'd0, sum4}, {64'd0, 64'h0000_0003_0001_0000});
    tick();

    // Reset during RUN drops the op.
    a_w = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}; b_w = {64'd0, 64'd1}; cin = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {127'd0, busy4}, 128'd0);
    check("midrst_done", {127'd0, done4}, 128'd0);
    check("midrst_sum", {64'd0, sum4}, 128'd0);
    check("midrst_cout", {127'd0, cout4}, 128'd0);
    check("midrst_ovf", {127'd0, ovf4}, 128'd0);
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4 || busy4) saw_done = 1;
    end
    check("midrst_no_done", 128'(saw_done), 128'd0);
    op4(64'd5, 64'd7, 1'b0, lat, bcnt);
    check("after_rst_sum", {64'd0, sum4}, 128'd12);
    check("after_rst_cout", {127'd0, cout4}, 128'd0);
    tick();

    // Random adds on all three widths against the reference model.
    for (int n = 0; n < 3000; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) rb = ~ra;
      if ($urandom_range(0, 7) == 0) ra = {4{32'h7FFF_FFFF}};
      a_w = ra; b_w = rb; cin = rc;
      start2 = 1'b1; start4 = 1'b1; start8 = 1'b1;
      tick();
      start2 = 1'b0; start4 = 1'b0; start8 = 1'b0;
      a_w = ~ra; b_w = ~rb; cin = ~rc;
      got2 = 1'b0; got4 = 1'b0; got8 = 1'b0;
      cyc = 0;
      while (!(got2 && got4 && got8) && cyc < 16) begin
        tick();
        cyc++;
        if (done2 && !got2) begin
          got2 = 1'b1;
          ref_add(32, ra, rb, rc, es, eco, eov);
          check("rand2_sum", {96'd0, sum2}, es);
          check("rand2_cout", {127'd0, cout2}, {127'd0, eco});
          check("rand2_ovf", {127'd0, ovf2}, {127'd0, eov});
        end
        if (done4 && !got4) begin
          got4 = 1'b1;
          ref_add(64, ra, rb, rc, es, eco, eov);
          check("rand4_sum", {64'd0, sum4}, es);
          check("rand4_cout", {127'd0, cout4}, {127'd0, eco});
          check("rand4_ovf", {127'd0, ovf4}, {127'd0, eov});
        end
        if (done8 && !got8) begin
          got8 = 1'b1;
          ref_add(128, ra, rb, rc, es, eco, eov);
          check("rand8_sum", sum8, es);
          check("rand8_cout", {127'd0, cout8}, {127'd0, eco});
          check("rand8_ovf", {127'd0, ovf8}, {127'd0, eov});
          check("rand8_latency", 128'(cyc), 128'd8);
        end
      end
      check("rand_all_done", {125'd0, got2, got4, got8}, 128'd7);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
